// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO with active-low strobes, occupancy count,
// almost-full/empty thresholds and pulse or sticky error flags.
module fifo_ctrl_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit STICKY_ERR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_n,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_n,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       over_flow,
  output logic                       under_flow,
  input  logic                       clr_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEP_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic full_s, empty_s;
  logic rd_acc, wr_acc;
  logic ovf_ev, unf_ev;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_s  = (cnt_q == DEP_C);
  assign empty_s = (cnt_q == '0);
  // A read frees a slot this cycle, so a write may proceed even when full.
  assign rd_acc  = !rd_n && !empty_s;
  assign wr_acc  = !wr_n && (!full_s || rd_acc);
  assign ovf_ev  = !wr_n && !wr_acc;
  assign unf_ev  = !rd_n && empty_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    if (wr_acc) wr_ptr_d = nxt(wr_ptr_q);
    if (rd_acc) begin
      rd_ptr_d = nxt(rd_ptr_q);
      rdata_d  = mem_q[rd_ptr_q];
    end
    unique case (1'b1)
      (wr_acc && !rd_acc): cnt_d = cnt_q + 1'b1;
      (rd_acc && !wr_acc): cnt_d = cnt_q - 1'b1;
      default:             cnt_d = cnt_q;
    endcase
    if (STICKY_ERR) begin
      ovf_d = ovf_ev || (ovf_q && !clr_err);
      unf_d = unf_ev || (unf_q && !clr_err);
    end else begin
      ovf_d = ovf_ev;
      unf_d = unf_ev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = rdata_q;
  assign rd_valid     = rvalid_q;
  assign count        = cnt_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign over_flow    = ovf_q;
  assign under_flow   = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Bench: three FIFO configurations driven in lockstep and compared
// against a list-based reference model every cycle.
module tb_fifo_ctrl_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] rdd [3];
  logic       rdv [3];
  logic       fl  [3];
  logic       em  [3];
  logic       af  [3];
  logic       ae  [3];
  logic       ov  [3];
  logic       un  [3];
  logic [4:0] c0, c2;
  logic [2:0] c1;

  int n_chk = 0;
  int n_fail = 0;

  int DEP [3] = '{16, 5, 16};
  int AFL [3] = '{14, 4, 14};
  int AEL [3] = '{2, 1, 2};
  bit STK [3] = '{1'b0, 1'b0, 1'b1};

  logic [7:0] md  [3][16];
  int         mn  [3];
  logic [7:0] mrd [3];
  bit         mrv [3];
  bit         mov [3];
  bit         mun [3];

  always #5 clk = ~clk;

  fifo_ctrl_param u0 (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_data(wr_data),
    .rd_n(rd_n), .rd_data(rdd[0]), .rd_valid(rdv[0]), .count(c0),
    .full(fl[0]), .empty(em[0]), .almost_full(af[0]),
    .almost_empty(ae[0]), .over_flow(ov[0]), .under_flow(un[0]),
    .clr_err(clr_err)
  );

  fifo_ctrl_param #(
    .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_data(wr_data),
    .rd_n(rd_n), .rd_data(rdd[1]), .rd_valid(rdv[1]), .count(c1),
    .full(fl[1]), .empty(em[1]), .almost_full(af[1]),
    .almost_empty(ae[1]), .over_flow(ov[1]), .under_flow(un[1]),
    .clr_err(clr_err)
  );

  fifo_ctrl_param #(
    .STICKY_ERR(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_data(wr_data),
    .rd_n(rd_n), .rd_data(rdd[2]), .rd_valid(rdv[2]), .count(c2),
    .full(fl[2]), .empty(em[2]), .almost_full(af[2]),
    .almost_empty(ae[2]), .over_flow(ov[2]), .under_flow(un[2]),
    .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(c0);
      1:       return 32'(c1);
      default: return 32'(c2);
    endcase
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.cnt%0d", ph, i), cnt_of(i), 32'(mn[i]));
      check($sformatf("%s.full%0d", ph, i), 32'(fl[i]),
            32'(mn[i] == DEP[i]));
      check($sformatf("%s.empty%0d", ph, i), 32'(em[i]),
            32'(mn[i] == 0));
      check($sformatf("%s.af%0d", ph, i), 32'(af[i]),
            32'(mn[i] >= AFL[i]));
      check($sformatf("%s.ae%0d", ph, i), 32'(ae[i]),
            32'(mn[i] <= AEL[i]));
      check($sformatf("%s.ovf%0d", ph, i), 32'(ov[i]), 32'(mov[i]));
      check($sformatf("%s.unf%0d", ph, i), 32'(un[i]), 32'(mun[i]));
      check($sformatf("%s.rdv%0d", ph, i), 32'(rdv[i]), 32'(mrv[i]));
      check($sformatf("%s.rdd%0d", ph, i), 32'(rdd[i]), 32'(mrd[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i]  = 0;
      mrd[i] = '0;
      mrv[i] = 1'b0;
      mov[i] = 1'b0;
      mun[i] = 1'b0;
    end
  endtask

  // Queue semantics: element 0 is the oldest entry.
  task automatic model_step(input bit w, input bit r, input bit c,
                            input logic [7:0] d);
    for (int i = 0; i < 3; i++) begin
      bit is_full, is_empty, racc, wacc, ovev, unev;
      is_full  = (mn[i] == DEP[i]);
      is_empty = (mn[i] == 0);
      racc = r && !is_empty;
      wacc = w && (!is_full || racc);
      ovev = w && !wacc;
      unev = r && is_empty;
      if (racc) begin
        mrd[i] = md[i][0];
        for (int k = 0; k < 15; k++) md[i][k] = md[i][k+1];
        mn[i]--;
      end
      mrv[i] = racc;
      if (wacc) begin
        md[i][mn[i]] = d;
        mn[i]++;
      end
      if (STK[i]) begin
        mov[i] = ovev || (mov[i] && !c);
        mun[i] = unev || (mun[i] && !c);
      end else begin
        mov[i] = ovev;
        mun[i] = unev;
      end
    end
  endtask

  task automatic step(input string ph, input bit w, input bit r,
                      input bit c, input logic [7:0] d);
    wr_n    = !w;
    rd_n    = !r;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    model_step(w, r, c, d);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset();
    wr_n    = 1'b1;
    rd_n    = 1'b1;
    clr_err = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    step("rel", 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rnd_run(input string ph, input int n, input int pw,
                         input int pr, input int pc);
    for (int k = 0; k < n; k++) begin
      step(ph, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < pc, 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    for (int k = 0; k < 17; k++) step("fill", 1, 0, 0, 8'($urandom));
    step("ovf_idle", 0, 0, 0, 8'h00);
    for (int k = 0; k < 17; k++) step("drain", 0, 1, 0, 8'h00);
    step("unf_idle", 0, 0, 0, 8'h00);

    for (int k = 0; k < 16; k++) step("refill", 1, 0, 0, 8'($urandom));
    for (int k = 0; k < 5; k++) step("both_full", 1, 1, 0, 8'($urandom));
    for (int k = 0; k < 16; k++) step("drain2", 0, 1, 0, 8'h00);
    step("both_empty", 1, 1, 0, 8'hA5);
    step("both_empty_idle", 0, 0, 0, 8'h00);

    do_reset();
    for (int k = 0; k < 12; k++) begin
      step("wrap", (k % 3) != 2, (k % 2) == 1, 0, 8'($urandom));
    end

    do_reset();
    for (int k = 0; k < 17; k++) step("sfill", 1, 0, 0, 8'($urandom));
    for (int k = 0; k < 10; k++) step("sidle", 0, 0, 0, 8'h00);
    step("sclr", 0, 0, 1, 8'h00);
    step("sclr_after", 0, 0, 0, 8'h00);
    step("sset_clr", 1, 0, 1, 8'h11);
    step("sset_after", 0, 0, 0, 8'h00);
    step("sclr2", 0, 0, 1, 8'h00);

    do_reset();
    for (int k = 0; k < 9; k++) step("mid", 1, 0, 0, 8'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    @(posedge clk);
    #1;
    check_all("async_hold");
    rst_n = 1'b1;
    step("async_rel", 0, 0, 0, 8'h00);
    step("post_rel_rd", 0, 1, 0, 8'h00);

    rnd_run("rnd_fill", 150, 80, 30, 10);
    rnd_run("rnd_mix", 300, 50, 50, 10);
    rnd_run("rnd_drain", 150, 30, 80, 10);
    rnd_run("rnd_mix2", 200, 55, 45, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised synchronous FIFO: storage, pointer control and status/error flagging in one block, replacing the fixed 16-deep controller.
- Active-low read/write strobes and the over_flow/under_flow error outputs keep their existing meaning, so current assertion suites still bind.
- New in this generation: configurable width/depth (including non-power-of-2), almost-full/almost-empty thresholds, occupancy count, and a sticky-error mode with software clear.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: number of entries; must be >= 2; need not be a power of 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- STICKY_ERR, 0: 0 = error flags are one-cycle pulses; 1 = error flags hold until clr_err or reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_n  input  1  active-low write request.
- wr_data  input  WIDTH  write data, sampled when wr_n = 0.
- rd_n  input  1  active-low read request.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  high for one cycle when rd_data holds newly read data.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- over_flow  output  1  a write was rejected.
- under_flow  output  1  a read was rejected.
- clr_err  input  1  clears sticky flags; ignored when STICKY_ERR = 0.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - wr_ptr = rd_ptr = 0; count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - over_flow = 0, under_flow = 0, rd_valid = 0, rd_data = 0.
  - Memory array is not reset.
  - Outputs hold these values for every cycle rst_n is low, and on the first edge after release.
- Write accept: wr_n = 0 and (!full, or read accepted in the same cycle). Action: mem[wr_ptr] <= wr_data, wr_ptr advances.
- Read accept: rd_n = 0 and !empty. Action: rd_data <= mem[rd_ptr], rd_valid <= 1, rd_ptr advances. Latency is 1 cycle from the strobe edge to rd_data.
- When no read is accepted: rd_valid <= 0 and rd_data holds its value.
- Pointer wrap: a pointer at DEPTH-1 goes to 0; no power-of-2 assumption.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- Flags are derived from count registers and are valid in the cycle after the edge that changed count.
- Simultaneous read and write:
  - When full: both accepted, count stays DEPTH, no over_flow.
  - When empty: write accepted, read rejected (no bypass), under_flow raised, count becomes 1.
- Overflow event: wr_n = 0 while full and no read accepted. Data is dropped; pointers and count are unchanged.
- Underflow event: rd_n = 0 while empty. Pointers and count are unchanged; rd_valid = 0.
- Flag timing:
  - STICKY_ERR = 0: the flag is high exactly one cycle, the cycle after the event edge.
  - STICKY_ERR = 1: the flag sets on the event and holds until clr_err = 1 is sampled. If an event and clr_err occur in the same cycle, set wins.
- Both errors in one cycle are impossible; full and empty are mutually exclusive.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Stored data is considered lost.

Test Plan:
- Reset, then 16 consecutive cycles of wr_n = 0, rd_n = 1 (DEPTH = 16) -> full = 1, count = 16, over_flow = 0. A 17th write -> over_flow = 1 on the next cycle only; count stays 16.
- From full, 16 consecutive cycles of rd_n = 0, wr_n = 1 -> data returns in write order, each word 1 cycle after its strobe, then empty = 1. A 17th read -> under_flow = 1 for one cycle, rd_valid = 0.
- At full, wr_n = rd_n = 0 for 5 cycles -> count holds 16, no over_flow, reads continue in order. At empty with both strobes low -> count = 1, under_flow = 1.
- DEPTH = 5, AF_LEVEL = 4, AE_LEVEL = 1, 12 interleaved write/read cycles:
  - Pointers wrap 4 -> 0 and data stays in order.
  - almost_full is high exactly when count >= 4.
  - almost_empty is high exactly when count <= 1.
- STICKY_ERR = 1: overflow, then 10 idle cycles -> over_flow stays 1. Assert clr_err -> 0 on the next cycle. Overflow coinciding with clr_err -> over_flow stays 1.
- rst_n dropped mid-fill at count = 9 -> all outputs return to reset values immediately, and the first cycle after release shows over_flow = under_flow = 0.
